// File: rtl/gx400_obj_linebuf.sv
// gx400_obj_linebuf: double-buffered object line buffer fed by the K005294
// sprite latch/MUX. Opaque pixels are written into the draw bank while the
// display bank is read out in raster order and cleared behind the beam.
// The banks swap once per line.
//
// Optional build macro: GX400_OBJLB_FIRSTWIN_EN
//   defined   -> first opaque sprite pixel at a location wins (the write is
//                deferred one MCLK so the stored word can be inspected)
//   undefined -> last opaque write wins (plain byte-enable write)
//
// Handshake: there is no valid/ready pair. Every input is sampled on MCLK
// edges with i_EMU_CLK6MPCEN_n low while in RUN. o_READY is a level that rises
// once the power-on clear sweep has finished, and it stays high until reset.
module gx400_obj_linebuf #(
  parameter int PXW        = 8,
  parameter int LINE_PAIRS = 128,
  parameter int AW         = 7
) (
  input  logic           i_EMU_MCLK,
  input  logic           i_EMU_RST_n,
  input  logic           i_EMU_CLK6MPCEN_n,
  input  logic [PXW-1:0] i_DA,
  input  logic [PXW-1:0] i_DB,
  input  logic [AW-1:0]  i_WRADDR,
  input  logic           i_WR_n,
  input  logic [AW:0]    i_HCNT,
  input  logic           i_RDCLR_n,
  input  logic           i_LINESWAP,
  output logic [PXW-1:0] o_PIXEL,
  output logic           o_READY,
  output logic           o_DRAWBANK
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t state_q, state_d;
  logic [AW-1:0] clr_ctr;

  // Two banks; low byte = even pixel, high byte = odd pixel.
  logic [2*PXW-1:0] mem [2][LINE_PAIRS];

  logic           en;
  logic           disp_bank;
  logic [AW-1:0]  rd_pair;
  logic [2*PXW-1:0] rd_word;
  logic           clr_go;
  logic           wr_lo_req, wr_hi_req;

  // Resolved write port into the memory (after optional first-win filtering).
  logic           w_lo, w_hi, w_bank;
  logic [AW-1:0]  w_addr;
  logic [PXW-1:0] w_lo_d, w_hi_d;

  assign en        = (state_q == ST_RUN) && !i_EMU_CLK6MPCEN_n;
  assign disp_bank = ~o_DRAWBANK;
  assign rd_pair   = i_HCNT[AW:1];
  assign rd_word   = mem[disp_bank][rd_pair];
  assign clr_go    = en && !i_RDCLR_n && i_HCNT[0];
  assign wr_lo_req = en && !i_WR_n && (i_DA[3:0] != 4'd0);
  assign wr_hi_req = en && !i_WR_n && (i_DB[3:0] != 4'd0);

  // Next-state: leave INIT once the last pair address has been cleared.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && clr_ctr == AW'(LINE_PAIRS - 1)) begin
      state_d = ST_RUN;
    end
  end

  // State register.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
    if (!i_EMU_RST_n) state_q <= ST_INIT;
    else              state_q <= state_d;
  end

  // Clear-sweep address counter, advances every MCLK while in INIT.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
    if (!i_EMU_RST_n)            clr_ctr <= '0;
    else if (state_q == ST_INIT) clr_ctr <= clr_ctr + AW'(1);
  end

  // Ready lags the INIT->RUN transition by one MCLK.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
    if (!i_EMU_RST_n) o_READY <= 1'b0;
    else              o_READY <= (state_q == ST_RUN);
  end

  // Bank select toggles on an enabled swap pulse.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
    if (!i_EMU_RST_n)           o_DRAWBANK <= 1'b0;
    else if (en && i_LINESWAP)  o_DRAWBANK <= ~o_DRAWBANK;
  end

  // Registered display pixel; held at zero during the clear sweep.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
    if (!i_EMU_RST_n)            o_PIXEL <= '0;
    else if (state_q == ST_INIT) o_PIXEL <= '0;
    else if (en)                 o_PIXEL <= i_HCNT[0] ? rd_word[2*PXW-1:PXW]
                                                      : rd_word[PXW-1:0];
  end

`ifdef GX400_OBJLB_FIRSTWIN_EN
  logic           pend_lo, pend_hi, pend_bank;
  logic [AW-1:0]  pend_addr;
  logic [PXW-1:0] pend_da, pend_db;
  logic [2*PXW-1:0] cur_word;

  // Capture the write request; it lands one MCLK later after inspecting memory.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
    if (!i_EMU_RST_n) begin
      pend_lo   <= 1'b0;
      pend_hi   <= 1'b0;
      pend_bank <= 1'b0;
      pend_addr <= '0;
      pend_da   <= '0;
      pend_db   <= '0;
    end else begin
      pend_lo   <= wr_lo_req;
      pend_hi   <= wr_hi_req;
      pend_bank <= o_DRAWBANK;
      pend_addr <= i_WRADDR;
      pend_da   <= i_DA;
      pend_db   <= i_DB;
    end
  end

  assign cur_word = mem[pend_bank][pend_addr];
  assign w_lo     = pend_lo && (cur_word[3:0] == 4'd0);
  assign w_hi     = pend_hi && (cur_word[PXW+3:PXW] == 4'd0);
  assign w_bank   = pend_bank;
  assign w_addr   = pend_addr;
  assign w_lo_d   = pend_da;
  assign w_hi_d   = pend_db;
`else
  assign w_lo   = wr_lo_req;
  assign w_hi   = wr_hi_req;
  assign w_bank = o_DRAWBANK;
  assign w_addr = i_WRADDR;
  assign w_lo_d = i_DA;
  assign w_hi_d = i_DB;
`endif

  // Memory: clear sweep in INIT, otherwise byte-enable writes and clear-behind.
  always_ff @(posedge i_EMU_MCLK) begin
    if (state_q == ST_INIT) begin
      mem[0][clr_ctr] <= '0;
      mem[1][clr_ctr] <= '0;
    end else begin
      if (w_lo)   mem[w_bank][w_addr][PXW-1:0]     <= w_lo_d;
      if (w_hi)   mem[w_bank][w_addr][2*PXW-1:PXW] <= w_hi_d;
      if (clr_go) mem[disp_bank][rd_pair]          <= '0;
    end
  end

endmodule

// File: tb/tb_gx400_obj_linebuf.sv
// Bench for gx400_obj_linebuf: directed line-buffer scenarios plus a random
// mix of writes, swaps and clearing reads checked against a reference model.
module tb_gx400_obj_linebuf;

  localparam int PXW = 8;
  localparam int LP  = 128;
  localparam int AW  = 7;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cen_n;
  logic [PXW-1:0] da, db;
  logic [AW-1:0]  wraddr;
  logic           wr_n;
  logic [AW:0]    hcnt;
  logic           rdclr_n;
  logic           lineswap;
  logic [PXW-1:0] pixel;
  logic           ready;
  logic           drawbank;

  int vectors = 0;
  int miscompares = 0;

  logic [PXW-1:0]   exp_q[$];
  logic [2*PXW-1:0] m [2][LP];
  logic             mdb;

  gx400_obj_linebuf #(.PXW(PXW), .LINE_PAIRS(LP), .AW(AW)) dut (
    .i_EMU_MCLK(clk), .i_EMU_RST_n(rst_n), .i_EMU_CLK6MPCEN_n(cen_n),
    .i_DA(da), .i_DB(db), .i_WRADDR(wraddr), .i_WR_n(wr_n),
    .i_HCNT(hcnt), .i_RDCLR_n(rdclr_n), .i_LINESWAP(lineswap),
    .o_PIXEL(pixel), .o_READY(ready), .o_DRAWBANK(drawbank)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    cen_n = 1'b1; wr_n = 1'b1; rdclr_n = 1'b1; lineswap = 1'b0;
    da = '0; db = '0; wraddr = '0;
  endtask

  task automatic model_clear();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < LP; a++) m[b][a] = '0;
    mdb = 1'b0;
  endtask

  // Reset pulse then the 128-MCLK clear sweep with junk on every input.
  task automatic reset_sweep(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk({tag, "_rst_bank"}, drawbank, 0);
    chk({tag, "_rst_pix"},  pixel, 0);
    chk({tag, "_rst_rdy"},  ready, 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    cen_n = 1'b0; wr_n = 1'b0; da = 8'hFF; db = 8'hFF; lineswap = 1'b1; rdclr_n = 1'b0;
    hcnt = 8'h0F;
    repeat (LP) @(posedge clk);
    @(negedge clk);
    idle();
    chk({tag, "_rdy_128"},  ready, 0);
    chk({tag, "_bank_init"}, drawbank, 0);
    chk({tag, "_pix_init"},  pixel, 0);
    @(negedge clk);
    chk({tag, "_rdy_129"},  ready, 1);
  endtask

  // One enabled cycle followed by one disabled cycle.
  task automatic wr(input logic [AW-1:0] a, input logic [7:0] dav, input logic [7:0] dbv,
                    input logic sw);
    @(negedge clk);
    cen_n = 1'b0; wr_n = 1'b0; wraddr = a; da = dav; db = dbv; lineswap = sw;
    @(posedge clk);
    @(negedge clk);
    idle();
    @(posedge clk);
`ifdef GX400_OBJLB_FIRSTWIN_EN
    if (dav[3:0] != 0 && m[mdb][a][3:0] == 0)   m[mdb][a][7:0]  = dav;
    if (dbv[3:0] != 0 && m[mdb][a][11:8] == 0)  m[mdb][a][15:8] = dbv;
`else
    if (dav[3:0] != 0) m[mdb][a][7:0]  = dav;
    if (dbv[3:0] != 0) m[mdb][a][15:8] = dbv;
`endif
    if (sw) mdb = ~mdb;
  endtask

  task automatic swap();
    @(negedge clk);
    cen_n = 1'b0; lineswap = 1'b1;
    @(posedge clk);
    @(negedge clk);
    idle();
    @(posedge clk);
    mdb = ~mdb;
  endtask

  task automatic rd(input logic [AW:0] h, input logic clr, input logic [7:0] exp,
                    input string tag);
    exp_q.push_back(exp);
    @(negedge clk);
    cen_n = 1'b0; hcnt = h; rdclr_n = ~clr;
    @(posedge clk);
    @(negedge clk);
    idle();
    chk(tag, pixel, exp_q.pop_front());
    @(posedge clk);
    if (clr && h[0]) m[~mdb][h[AW:1]] = '0;
  endtask

  task automatic rd_m(input logic [AW:0] h, input logic clr, input string tag);
    logic [15:0] w;
    w = m[~mdb][h[AW:1]];
    rd(h, clr, h[0] ? w[15:8] : w[7:0], tag);
  endtask

  initial begin
    rst_n = 1'b0;
    hcnt = '0;
    idle();
    model_clear();
    repeat (2) @(negedge clk);
    reset_sweep("por");

    // Every pixel of both banks reads zero after the sweep.
    for (int i = 0; i < 2*LP; i++) rd(AW'(0) + (AW+1)'(i), 1'b0, 8'h00, "init_zero_b1");
    swap();
    for (int i = 0; i < 2*LP; i++) rd((AW+1)'(i), 1'b0, 8'h00, "init_zero_b0");

    // Transparent odd pixel leaves the stored half at zero.
    wr(7'd5, 8'h35, 8'h70, 1'b0);
    swap();
    rd(8'd10, 1'b0, 8'h35, "even_opaque");
    rd(8'd11, 1'b0, 8'h00, "odd_transp");

    // Two opaque writes to the same pair.
    wr(7'd3, 8'h21, 8'h00, 1'b0);
    wr(7'd3, 8'h4F, 8'h00, 1'b0);
    swap();
`ifdef GX400_OBJLB_FIRSTWIN_EN
    rd(8'd6, 1'b0, 8'h21, "overlap_first");
`else
    rd(8'd6, 1'b0, 8'h4F, "overlap_last");
`endif

    // Clear-behind returns pre-clear data, then the word reads zero.
    wr(7'd7, 8'h1C, 8'h9A, 1'b0);
    swap();
    rd(8'd14, 1'b1, 8'h1C, "clr_even");
    rd(8'd15, 1'b1, 8'h9A, "clr_odd");
    swap();
    swap();
    rd(8'd14, 1'b0, 8'h00, "cleared_even");
    rd(8'd15, 1'b0, 8'h00, "cleared_odd");

    // Write in the swap cycle goes to the old draw bank.
    wr(7'd0, 8'h11, 8'h00, 1'b1);
    rd(8'd0, 1'b0, 8'h11, "swap_same_cycle");
    chk("bank_after_swapwr", drawbank, mdb);

    // Disabled cycles change nothing.
    @(negedge clk);
    cen_n = 1'b1; lineswap = 1'b1; wr_n = 1'b0; da = 8'h77; wraddr = 7'd0; hcnt = 8'd1;
    @(posedge clk);
    @(negedge clk);
    idle();
    chk("noen_swap", drawbank, mdb);
    chk("noen_pix", pixel, 8'h11);

    // Random mix checked against the model.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0, 1: wr(AW'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 1'($urandom_range(0, 7) == 0));
        2: swap();
        default: rd_m((AW+1)'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), "rand_rd");
      endcase
    end
    for (int i = 0; i < 32; i++) rd_m((AW+1)'(i), 1'b0, "rand_sweep");

    // Reset mid-line with the draw bank at 1.
    if (!mdb) swap();
    chk("bank_before_rst", drawbank, 1);
    reset_sweep("mid");
    for (int i = 0; i < 2*LP; i++) rd((AW+1)'(i), 1'b0, 8'h00, "reclr_b1");
    swap();
    for (int i = 0; i < 2*LP; i++) rd((AW+1)'(i), 1'b0, 8'h00, "reclr_b0");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
